tick_generator: RTL and testbench

Parametrised multi-channel clock-enable generator for the Nexys 100 MHz domain. It replaces the fixed pixel-rate and alarm dividers with NUM_CH independent channels. Each channel has a runtime-programmable divisor with glitch-free shadow reload, a one-cycle tick enable and a 50 % square output. It sits at the top of the video/alarm datapath and feeds the VGA pixel enable, the alarm blinker and any future timebase.

---
 rtl/tick_generator.sv | 104 ++++++++++
 tb/tb_tick_generator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_generator.sv
// tick_generator: NUM_CH independent clock-enable channels with shadowed divisors.
// Each channel emits a one-cycle tick every div+1 cycles plus a 50% square wave.
//
// Ports:
//   clk_nexys  100 MHz system clock
//   rst        asynchronous, active-high reset
//   ch_en      per-channel run enable (level)
//   sync_clr   realign the phase of all channels
//   cfg_we     divisor write strobe
//   cfg_ch     divisor write target channel
//   cfg_div    new divisor value
//   cfg_ack    write accepted (one cycle after cfg_we)
//   cfg_err    write dropped, channel out of range
//   pending    shadow divisor waiting for reload
//   tick       one-cycle enable per channel
//   sq         square wave, toggles on each tick
module tick_generator #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 24,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = '0
) (
  input  logic              clk_nexys,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [CNT_W-1:0]  div_act [NUM_CH];
  logic [CNT_W-1:0]  div_shd [NUM_CH];
  logic              cfg_ok;
  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] term;

  assign cfg_ok = int'(cfg_ch) < NUM_CH;

  always_comb begin
    wr_sel = '0;
    term   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = cfg_we && cfg_ok && (int'(cfg_ch) == i);
      term[i]   = cnt[i] == div_act[i];
    end
  end

  always_ff @(posedge clk_nexys or posedge rst) begin
    if (rst) begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      pending <= '0;
      tick    <= '0;
      sq      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]     <= '0;
        div_act[i] <= DIV_INIT[i*CNT_W +: CNT_W];
        div_shd[i] <= DIV_INIT[i*CNT_W +: CNT_W];
      end
    end else begin
      cfg_ack <= cfg_we && cfg_ok;
      cfg_err <= cfg_we && !cfg_ok;
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync_clr) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
          sq[i]   <= 1'b0;
        end else if (!ch_en[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
          sq[i]   <= 1'b0;
          if (pending[i]) begin
            div_act[i] <= div_shd[i];
            pending[i] <= 1'b0;
          end
        end else if (term[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b1;
          sq[i]   <= ~sq[i];
          if (pending[i]) begin
            div_act[i] <= div_shd[i];
            pending[i] <= 1'b0;
          end
        end else begin
          cnt[i]  <= cnt[i] + CNT_W'(1);
          tick[i] <= 1'b0;
        end
        // A write wins over a same-cycle reload: the reload
        // takes the old shadow, the new value stays pending.
        if (wr_sel[i]) begin
          div_shd[i] <= cfg_div;
          pending[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_generator.sv
// tb_tick_generator: directed plus random stimulus for tick_generator,
// checked every cycle against a tick-scheduling reference model.
module tb_tick_generator;

  localparam int NCH = 4;
  localparam int W   = 24;
  localparam logic [NCH*W-1:0] INIT = {24'd0, 24'd0, 24'd9, 24'd1};

  logic           clk_nexys = 1'b0;
  logic           rst       = 1'b1;
  logic [NCH-1:0] ch_en     = '0;
  logic           sync_clr  = 1'b0;
  logic           cfg_we    = 1'b0;
  logic [3:0]     cfg_ch    = '0;
  logic [W-1:0]   cfg_div   = '0;
  logic           cfg_ack;
  logic           cfg_err;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] sq;

  tick_generator #(
    .NUM_CH  (NCH),
    .CNT_W   (W),
    .DIV_INIT(INIT)
  ) dut (
    .clk_nexys(clk_nexys),
    .rst      (rst),
    .ch_en    (ch_en),
    .sync_clr (sync_clr),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_ack  (cfg_ack),
    .cfg_err  (cfg_err),
    .pending  (pending),
    .tick     (tick),
    .sq       (sq)
  );

  always #5 clk_nexys = ~clk_nexys;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: each channel keeps the absolute edge number of its next tick.
  int             cyc = 0;
  int             due   [NCH];
  int             m_act [NCH];
  int             m_shd [NCH];
  logic [NCH-1:0] m_pend, m_tick, m_sq;
  logic           m_ack, m_err;

  function automatic void m_reset();
    logic [W-1:0] v;
    for (int i = 0; i < NCH; i++) begin
      v        = INIT[i*W +: W];
      m_act[i] = int'(v);
      m_shd[i] = int'(v);
      due[i]   = cyc + m_act[i] + 1;
    end
    m_pend = '0;
    m_tick = '0;
    m_sq   = '0;
    m_ack  = 1'b0;
    m_err  = 1'b0;
  endfunction

  function automatic void m_edge();
    bit wr_ok;
    cyc++;
    if (rst) begin
      m_reset();
      return;
    end
    wr_ok = cfg_we && (int'(cfg_ch) < NCH);
    m_ack = wr_ok;
    m_err = cfg_we && !wr_ok;
    for (int i = 0; i < NCH; i++) begin
      if (sync_clr) begin
        m_tick[i] = 1'b0;
        m_sq[i]   = 1'b0;
        due[i]    = cyc + m_act[i] + 1;
      end else if (!ch_en[i]) begin
        m_tick[i] = 1'b0;
        m_sq[i]   = 1'b0;
        if (m_pend[i]) begin
          m_act[i]  = m_shd[i];
          m_pend[i] = 1'b0;
        end
        due[i] = cyc + m_act[i] + 1;
      end else if (cyc == due[i]) begin
        m_tick[i] = 1'b1;
        m_sq[i]   = ~m_sq[i];
        if (m_pend[i]) begin
          m_act[i]  = m_shd[i];
          m_pend[i] = 1'b0;
        end
        due[i] = cyc + m_act[i] + 1;
      end else begin
        m_tick[i] = 1'b0;
      end
      if (wr_ok && int'(cfg_ch) == i) begin
        m_shd[i]  = int'(cfg_div);
        m_pend[i] = 1'b1;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk_nexys);
    m_edge();
    #1;
    check("tick", 32'(tick), 32'(m_tick));
    check("sq", 32'(sq), 32'(m_sq));
    check("pending", 32'(pending), 32'(m_pend));
    check("cfg_ack", 32'(cfg_ack), 32'(m_ack));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic cfg(input int ch, input int dv);
    cfg_we  = 1'b1;
    cfg_ch  = 4'(ch);
    cfg_div = W'(dv);
    step();
    cfg_we  = 1'b0;
  endtask

  task automatic wait_tick(input int ch, output int at);
    at = -1;
    for (int k = 0; k < 64; k++) begin
      step();
      if (tick[ch]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("tick_timeout", 0, 1);
  endtask

  task automatic wait_due(input int ch);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (due[ch] == cyc + 1) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    if (!hit) check("due_timeout", 0, 1);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    check("rst_tick", 32'(tick), 0);
    check("rst_sq", 32'(sq), 0);
    check("rst_pend", 32'(pending), 0);
    m_reset();
    #1;
    rst = 1'b0;
  endtask

  int t0, ta, tb;
  logic [NCH-1:0] pend_save;

  initial begin
    m_reset();
    ch_en = 4'b0011;
    steps(3);
    rst = 1'b0;
    steps(40);

    // divisor 0 on a disabled channel, then enable
    cfg(2, 0);
    check("div0_ack", 32'(cfg_ack), 1);
    step();
    check("div0_ack_once", 32'(cfg_ack), 0);
    ch_en[2] = 1'b1;
    steps(4);
    check("div0_tick", 32'(tick[2]), 1);
    step();
    check("div0_tick2", 32'(tick[2]), 1);

    // mid-period reload at cnt1 == 3
    wait_tick(1, t0);
    steps(3);
    cfg(1, 4);
    check("mid_pend", 32'(pending[1]), 1);
    wait_tick(1, ta);
    check("mid_first", 32'(ta - t0), 10);
    wait_tick(1, tb);
    check("mid_next", 32'(tb - ta), 5);

    // write coincident with terminal count while 4 is pending
    cfg(1, 4);
    wait_due(1);
    cfg(1, 2);
    t0 = cyc;
    check("coin_tick", 32'(tick[1]), 1);
    check("coin_pend", 32'(pending[1]), 1);
    wait_tick(1, ta);
    check("coin_p5", 32'(ta - t0), 5);
    wait_tick(1, tb);
    check("coin_p3", 32'(tb - ta), 3);
    check("coin_clr", 32'(pending[1]), 0);

    // out-of-range channel
    pend_save = pending;
    cfg(7, 5);
    check("inv_err", 32'(cfg_err), 1);
    check("inv_ack", 32'(cfg_ack), 0);
    check("inv_pend", 32'(pending), 32'(pend_save));

    // asynchronous reset mid-count with a write pending
    ch_en = 4'b1111;
    cfg(1, 3);
    steps(3);
    rst_pulse();
    steps(25);

    // sync_clr realignment
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    t0 = cyc;
    wait_tick(0, ta);
    check("clr_ch0", 32'(ta - t0), 2);
    wait_tick(1, tb);
    check("clr_ch1", 32'(tb - t0), 10);

    // drop ch_en1 while sq1 is high
    ch_en[1] = 1'b0;
    step();
    check("off_sq1", 32'(sq[1]), 0);
    check("off_tick1", 32'(tick[1]), 0);
    ch_en[1] = 1'b1;
    steps(5);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      cfg_we   = ($urandom % 6) == 0;
      cfg_ch   = 4'($urandom % 8);
      cfg_div  = W'($urandom % 13);
      sync_clr = ($urandom % 64) == 0;
      if (($urandom % 24) == 0) ch_en[$urandom % NCH] ^= 1'b1;
      step();
      if (($urandom % 400) == 0) rst_pulse();
    end
    cfg_we   = 1'b0;
    sync_clr = 1'b0;
    steps(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
